fetch_queue_unit: RTL

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_ring.sv | 76 +++++++
 rtl/fetch_queue_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: parameter defaults,
// the sequential PC step and the queue entry record.
package fetch_pkg;

   localparam int PC_WIDTH_DEF    = 10;
   localparam int INSTR_WIDTH_DEF = 32;
   localparam int DEPTH_DEF       = 4;
   localparam int RESET_PC_DEF    = 0;
   localparam int PC_STEP_DEF     = 4;

   // Entry fields are sized for the widest supported configuration; narrower
   // instances zero-extend on write and truncate on read.
   localparam int PC_WIDTH_MAX    = 32;
   localparam int INSTR_WIDTH_MAX = 64;

   typedef struct packed {
      logic                       valid;
      logic                       filled;
      logic [PC_WIDTH_MAX-1:0]    pc;
      logic [INSTR_WIDTH_MAX-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// DEPTH-entry in-order fetch storage: entries are allocated at request time,
// filled by responses in order, and popped from the head.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       alloc_en,
   input  logic [PC_WIDTH-1:0]        alloc_pc,
   input  logic                       fill_en,
   input  logic [INSTR_WIDTH-1:0]     fill_instr,
   input  logic                       pop_en,
   output logic                       head_filled,
   output logic [PC_WIDTH-1:0]        head_pc,
   output logic [INSTR_WIDTH-1:0]     head_instr,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [$clog2(DEPTH+1)-1:0] pending
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   fetch_entry_t      entries_r [DEPTH];
   logic [PW-1:0]     alloc_ptr_r;
   logic [PW-1:0]     fill_ptr_r;
   logic [PW-1:0]     head_ptr_r;
   logic [LW-1:0]     level_r;
   logic [LW-1:0]     pending_r;

   // Pop, allocate and fill never target the same slot in one cycle, so the
   // three updates below are independent.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i].valid  <= 1'b0;
            entries_r[i].filled <= 1'b0;
         end
         alloc_ptr_r <= '0;
         fill_ptr_r  <= '0;
         head_ptr_r  <= '0;
         level_r     <= '0;
         pending_r   <= '0;
      end else begin
         if (pop_en) begin
            entries_r[head_ptr_r].valid  <= 1'b0;
            entries_r[head_ptr_r].filled <= 1'b0;
            head_ptr_r                   <= head_ptr_r + PW'(1);
         end
         if (alloc_en) begin
            entries_r[alloc_ptr_r].valid  <= 1'b1;
            entries_r[alloc_ptr_r].filled <= 1'b0;
            entries_r[alloc_ptr_r].pc     <= PC_WIDTH_MAX'(alloc_pc);
            alloc_ptr_r                   <= alloc_ptr_r + PW'(1);
         end
         if (fill_en) begin
            entries_r[fill_ptr_r].filled <= 1'b1;
            entries_r[fill_ptr_r].instr  <= INSTR_WIDTH_MAX'(fill_instr);
            fill_ptr_r                   <= fill_ptr_r + PW'(1);
         end
         level_r   <= level_r + LW'(alloc_en) - LW'(pop_en);
         pending_r <= pending_r + LW'(alloc_en) - LW'(fill_en);
      end
   end

   assign head_filled = entries_r[head_ptr_r].valid && entries_r[head_ptr_r].filled;
   assign head_pc     = PC_WIDTH'(entries_r[head_ptr_r].pc);
   assign head_instr  = INSTR_WIDTH'(entries_r[head_ptr_r].instr);
   assign level       = level_r;
   assign pending     = pending_r;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch queue: issues sequential instruction fetches under a credit limit,
// drops stale responses after redirects and delivers instructions in order.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int RESET_PC    = RESET_PC_DEF,
   parameter int PC_STEP     = PC_STEP_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req_valid,
   output logic [PC_WIDTH-1:0]        imem_req_addr,
   input  logic                       imem_req_ready,
   input  logic                       imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0]     imem_rsp_data,
   input  logic                       redirect_valid,
   input  logic [PC_WIDTH-1:0]        redirect_pc,
   output logic                       out_valid,
   output logic [INSTR_WIDTH-1:0]     out_instr,
   output logic [PC_WIDTH-1:0]        out_pc,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int LW = $clog2(DEPTH+1);

   logic                run_r;
   logic [PC_WIDTH-1:0] fetch_pc_r;
   logic [LW-1:0]       discard_cnt_r;
   logic [LW-1:0]       discard_next_s;
   logic [LW-1:0]       level_s;
   logic [LW-1:0]       pending_s;
   logic [LW:0]         outstanding_s;
   logic                accept_s;
   logic                alloc_s;
   logic                fill_s;
   logic                pop_s;
   logic                rsp_stale_s;
   logic                head_filled_s;

   // Credit covers both live entries and responses still owed for discarded
   // requests, so the memory never has more than DEPTH answers in flight.
   assign outstanding_s  = {1'b0, level_s} + {1'b0, discard_cnt_r};
   assign imem_req_valid = run_r && (outstanding_s < (LW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_r;
   assign accept_s       = imem_req_valid && imem_req_ready;

   assign rsp_stale_s = imem_rsp_valid && (discard_cnt_r != '0);
   assign fill_s      = imem_rsp_valid && !redirect_valid && !rsp_stale_s;
   assign alloc_s     = accept_s && !redirect_valid;
   assign pop_s       = head_filled_s && out_ready && !redirect_valid;

   // On redirect every unanswered request becomes a discard, less any
   // response consumed in the same cycle.
   always_comb begin
      discard_next_s = discard_cnt_r;
      if (redirect_valid) begin
         discard_next_s = discard_cnt_r + pending_s + LW'(accept_s) - LW'(imem_rsp_valid);
      end else if (rsp_stale_s) begin
         discard_next_s = discard_cnt_r - LW'(1);
      end else begin
         discard_next_s = discard_cnt_r;
      end
   end

   // Control state: run enable, fetch PC and stale-response counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run_r         <= 1'b0;
         fetch_pc_r    <= PC_WIDTH'(RESET_PC);
         discard_cnt_r <= '0;
      end else begin
         run_r         <= 1'b1;
         discard_cnt_r <= discard_next_s;
         if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
         end else if (accept_s) begin
            fetch_pc_r <= fetch_pc_r + PC_WIDTH'(PC_STEP);
         end
      end
   end

   fetch_ring #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH),
      .DEPTH       (DEPTH)
   ) u_ring (
      .clk         (clk),
      .reset       (reset),
      .flush       (redirect_valid),
      .alloc_en    (alloc_s),
      .alloc_pc    (fetch_pc_r),
      .fill_en     (fill_s),
      .fill_instr  (imem_rsp_data),
      .pop_en      (pop_s),
      .head_filled (head_filled_s),
      .head_pc     (out_pc),
      .head_instr  (out_instr),
      .level       (level_s),
      .pending     (pending_s)
   );

   assign out_valid = head_filled_s;
   assign level     = level_s;

endmodule
